// File: rtl/cpsr_reg_pkg.sv
// Shared CPSR layout constants for the ARM core: flag bit positions,
// MSR field byte indices, control bit positions and the reset value.
package cpsr_reg_pkg;

  // Condition flag bit positions within the CPSR.
  localparam int CPSR_N = 31;
  localparam int CPSR_Z = 30;
  localparam int CPSR_C = 29;
  localparam int CPSR_V = 28;

  // Control bit positions; the mode field occupies [4:0].
  localparam int CPSR_I = 7;
  localparam int CPSR_F = 6;
  localparam int CPSR_T = 5;
  localparam int CPSR_M_HI = 4;

  // MSR field-mask bit index for each CPSR byte: f=[31:24] ... c=[7:0].
  localparam int FIELD_F = 3;
  localparam int FIELD_S = 2;
  localparam int FIELD_X = 1;
  localparam int FIELD_C = 0;

  localparam logic [4:0]  MODE_USR   = 5'b10000;
  localparam logic [31:0] CPSR_RESET = 32'h0000_00D3;

  // User mode may only touch the flags byte through MSR.
  function automatic logic [3:0] msr_byte_enables(input logic [3:0] field_mask,
                                                  input logic       user_mode);
    logic [3:0] en;
    en = field_mask;
    if (user_mode) begin
      en[FIELD_S] = 1'b0;
      en[FIELD_X] = 1'b0;
      en[FIELD_C] = 1'b0;
    end
    return en;
  endfunction

endpackage

// File: rtl/cpsr_reg_flag_scoreboard.sv
// Pending flag-writer counter. Tells issue logic whether an older
// flag-setting instruction has yet to write back, and records misuse.
//
// Claim/retire handshake: flag_claim is a one-cycle pulse per issued
// flag-setting instruction (issue must hold it low while claim_full=1);
// retire is a one-cycle pulse per ALU flag writeback. There is no ready
// signal: every pulse is consumed on the rising edge it is sampled.
// A claim while full or a retire while empty leaves the count alone and
// sets a sticky error bit that only reset clears. flush zeroes the count
// and takes priority over claim/retire in the same cycle.
module flag_scoreboard
  #(
    parameter int MAX_PENDING = 3,
    parameter int CW          = $clog2(MAX_PENDING + 1)
  )
  (
    input  logic clk,
    input  logic rst_n,
    input  logic claim,
    input  logic retire,
    input  logic flush,
    output logic flags_busy,
    output logic claim_full,
    output logic err_overflow,
    output logic err_underflow
  );

  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_PENDING);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;
  logic          ovf_hit;
  logic          unf_hit;

  // Next count and boundary detection for this cycle's claim/retire/flush.
  always_comb begin
    count_d = count_q;
    ovf_hit = 1'b0;
    unf_hit = 1'b0;
    if (flush) begin
      count_d = '0;
    end else if (claim && !retire) begin
      if (count_q == CNT_MAX) ovf_hit = 1'b1;
      else                    count_d = count_q + 1'b1;
    end else if (retire && !claim) begin
      if (count_q == '0) unf_hit = 1'b1;
      else               count_d = count_q - 1'b1;
    end
  end

  // Counter, status flags (mirroring the new count) and sticky errors.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q       <= '0;
      flags_busy    <= 1'b0;
      claim_full    <= 1'b0;
      err_overflow  <= 1'b0;
      err_underflow <= 1'b0;
    end else begin
      count_q       <= count_d;
      flags_busy    <= (count_d != '0);
      claim_full    <= (count_d == CNT_MAX);
      err_overflow  <= err_overflow  | ovf_hit;
      err_underflow <= err_underflow | unf_hit;
    end
  end

endmodule

// File: rtl/cpsr_reg.sv
// Architectural CPSR register: merges ALU flag writebacks and MSR writes,
// exposes a same-cycle bypass, and tracks pending flag writers.
module cpsr_reg
  import cpsr_reg_pkg::*;
  #(
    parameter int          MAX_PENDING = 3,
    parameter logic [31:0] RESET_CPSR  = 32'h0000_00D3
  )
  (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flag_claim,
    input  logic        flush,
    input  logic        alu_wr_en,
    input  logic [3:0]  alu_nzcv,
    input  logic [3:0]  alu_nzcv_mask,
    input  logic        msr_wr_en,
    input  logic [31:0] msr_data,
    input  logic [3:0]  msr_field_mask,
    output logic [31:0] cpsr_out,
    output logic [31:0] cpsr_next,
    output logic        flags_busy,
    output logic        claim_full,
    output logic        err_overflow,
    output logic        err_underflow
  );

  logic [31:0] cpsr_q;
  logic [3:0]  msr_en;
  logic        user_mode;
  logic        msr_owns_flags;

  assign user_mode = (cpsr_q[CPSR_M_HI:0] == MODE_USR);

  // Effective MSR byte enables after the user-mode restriction.
  always_comb begin
    msr_en = 4'b0000;
    if (msr_wr_en) msr_en = msr_byte_enables(msr_field_mask, user_mode);
    msr_owns_flags = msr_en[FIELD_F];
  end

  // Merge: ALU flags first (dropped if MSR rewrites the f byte), then MSR bytes.
  always_comb begin
    cpsr_next = cpsr_q;
    if (alu_wr_en && !msr_owns_flags) begin
      for (int i = 0; i < 4; i++) begin
        if (alu_nzcv_mask[i]) cpsr_next[CPSR_V + i] = alu_nzcv[i];
      end
    end
    for (int k = 0; k < 4; k++) begin
      if (msr_en[k]) cpsr_next[8*k +: 8] = msr_data[8*k +: 8];
    end
  end

  // Architectural register; a write becomes visible one edge later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cpsr_q <= RESET_CPSR;
    else        cpsr_q <= cpsr_next;
  end

  assign cpsr_out = cpsr_q;

  // A flushed ALU writeback still counts as a retire; flush zeroes the count anyway.
  flag_scoreboard #(.MAX_PENDING(MAX_PENDING)) u_scoreboard (
    .clk           (clk),
    .rst_n         (rst_n),
    .claim         (flag_claim),
    .retire        (alu_wr_en),
    .flush         (flush),
    .flags_busy    (flags_busy),
    .claim_full    (claim_full),
    .err_overflow  (err_overflow),
    .err_underflow (err_underflow)
  );

endmodule

// File: tb/tb_cpsr_reg.sv
// Self-checking bench for cpsr_reg: directed scenarios with literal
// expectations, then randomized traffic against a behavioural model.
module tb_cpsr_reg;

  localparam int          MAXP  = 3;
  localparam logic [31:0] RST_V = 32'h0000_00D3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flag_claim = 1'b0;
  logic        flush = 1'b0;
  logic        alu_wr_en = 1'b0;
  logic [3:0]  alu_nzcv = 4'h0;
  logic [3:0]  alu_nzcv_mask = 4'h0;
  logic        msr_wr_en = 1'b0;
  logic [31:0] msr_data = 32'h0;
  logic [3:0]  msr_field_mask = 4'h0;
  logic [31:0] cpsr_out;
  logic [31:0] cpsr_next;
  logic        flags_busy;
  logic        claim_full;
  logic        err_overflow;
  logic        err_underflow;

  int n_tests = 0;
  int n_fail  = 0;

  cpsr_reg #(.MAX_PENDING(MAXP), .RESET_CPSR(RST_V)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .flag_claim     (flag_claim),
    .flush          (flush),
    .alu_wr_en      (alu_wr_en),
    .alu_nzcv       (alu_nzcv),
    .alu_nzcv_mask  (alu_nzcv_mask),
    .msr_wr_en      (msr_wr_en),
    .msr_data       (msr_data),
    .msr_field_mask (msr_field_mask),
    .cpsr_out       (cpsr_out),
    .cpsr_next      (cpsr_next),
    .flags_busy     (flags_busy),
    .claim_full     (claim_full),
    .err_overflow   (err_overflow),
    .err_underflow  (err_underflow)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- checker helper ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] m_cpsr;
  int          m_count;
  bit          m_ovf;
  bit          m_unf;

  // CPSR after one cycle, computed byte by byte from the architectural rules.
  function automatic logic [31:0] model_next(input logic [31:0] cur);
    logic [7:0] bytes [4];
    logic [3:0] flags;
    bit         user;
    bit         msr_takes_f;
    for (int k = 0; k < 4; k++) bytes[k] = cur[8*k +: 8];
    user        = (cur[4:0] == 5'b10000);
    msr_takes_f = msr_wr_en && msr_field_mask[3];
    flags       = bytes[3][7:4];
    if (alu_wr_en && !msr_takes_f)
      flags = (flags & ~alu_nzcv_mask) | (alu_nzcv & alu_nzcv_mask);
    bytes[3] = {flags, bytes[3][3:0]};
    for (int k = 0; k < 4; k++) begin
      if (msr_wr_en && msr_field_mask[k] && (k == 3 || !user))
        bytes[k] = msr_data[8*k +: 8];
    end
    return {bytes[3], bytes[2], bytes[1], bytes[0]};
  endfunction

  // Model state advances on the same edges as the DUT.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cpsr  = RST_V;
      m_count = 0;
      m_ovf   = 1'b0;
      m_unf   = 1'b0;
    end else begin
      m_cpsr = model_next(m_cpsr);
      if (flush) m_count = 0;
      else if (flag_claim && !alu_wr_en) begin
        if (m_count == MAXP) m_ovf = 1'b1;
        else                 m_count = m_count + 1;
      end else if (alu_wr_en && !flag_claim) begin
        if (m_count == 0) m_unf = 1'b1;
        else              m_count = m_count - 1;
      end
    end
  end

  // ---------------- scoreboard compare (every falling edge) ----------------
  always @(negedge clk) begin
    chk("cpsr_out",      cpsr_out,              m_cpsr);
    chk("cpsr_next",     cpsr_next,             model_next(m_cpsr));
    chk("flags_busy",    {31'b0, flags_busy},   {31'b0, m_count != 0});
    chk("claim_full",    {31'b0, claim_full},   {31'b0, m_count == MAXP});
    chk("err_overflow",  {31'b0, err_overflow}, {31'b0, m_ovf});
    chk("err_underflow", {31'b0, err_underflow},{31'b0, m_unf});
  end

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    flag_claim = 0; flush = 0; alu_wr_en = 0; alu_nzcv = 0; alu_nzcv_mask = 0;
    msr_wr_en = 0; msr_data = 0; msr_field_mask = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_msr(input logic [31:0] data, input logic [3:0] mask, input logic claim);
    idle_inputs();
    msr_wr_en = 1; msr_data = data; msr_field_mask = mask; flag_claim = claim;
    step();
  endtask

  task automatic do_claims(input int n);
    for (int i = 0; i < n; i++) begin
      idle_inputs();
      flag_claim = 1;
      step();
    end
    idle_inputs();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    idle_inputs();
    rst_n = 0;
    repeat (3) step();
    rst_n = 1;
    step();

    // Reset state.
    chk("lit_reset_cpsr", cpsr_out, 32'h0000_00D3);
    chk("lit_reset_busy", {31'b0, flags_busy}, 32'h0);
    chk("lit_reset_full", {31'b0, claim_full}, 32'h0);

    // NZCV=0001 via MSR f, with one claim so the ALU write below retires it.
    do_msr(32'h1000_0000, 4'b1000, 1'b1);
    idle_inputs();
    chk("lit_msr_f", cpsr_out, 32'h1000_00D3);

    // ALU nzcv=0110 mask=1110 -> 0111, bypass same cycle, register next.
    alu_wr_en = 1; alu_nzcv = 4'b0110; alu_nzcv_mask = 4'b1110;
    #1;
    chk("lit_alu_bypass", {28'b0, cpsr_next[31:28]}, 32'h7);
    step();
    idle_inputs();
    chk("lit_alu_reg", {28'b0, cpsr_out[31:28]}, 32'h7);
    chk("lit_alu_busy_drop", {31'b0, flags_busy}, 32'h0);

    // Fill to MAX_PENDING, then overflow.
    do_claims(3);
    chk("lit_full", {31'b0, claim_full}, 32'h1);
    do_claims(1);
    chk("lit_ovf", {31'b0, err_overflow}, 32'h1);
    chk("lit_ovf_full", {31'b0, claim_full}, 32'h1);
    // Claim and retire together: count holds at full.
    flag_claim = 1; alu_wr_en = 1; alu_nzcv_mask = 4'b0000;
    step();
    idle_inputs();
    chk("lit_claim_retire", {31'b0, claim_full}, 32'h1);
    flush = 1;
    step();
    idle_inputs();
    chk("lit_flush_busy", {31'b0, flags_busy}, 32'h0);
    chk("lit_ovf_sticky", {31'b0, err_overflow}, 32'h1);

    // Enter user mode, then a full-mask MSR only updates the f byte.
    do_msr(32'h0000_0010, 4'b0001, 1'b0);
    chk("lit_user_mode", cpsr_out, 32'h7000_0010);
    do_msr(32'hF000_00DF, 4'b1111, 1'b0);
    idle_inputs();
    chk("lit_user_msr", cpsr_out, 32'hF000_0010);

    // MSR f and ALU together: MSR wins the flags, retire still counted.
    do_claims(1);
    msr_wr_en = 1; msr_data = 32'h8000_0000; msr_field_mask = 4'b1000;
    alu_wr_en = 1; alu_nzcv = 4'b0101; alu_nzcv_mask = 4'b1111;
    step();
    idle_inputs();
    chk("lit_msr_vs_alu", cpsr_out, 32'h8000_0010);
    chk("lit_msr_vs_alu_busy", {31'b0, flags_busy}, 32'h0);

    // Asynchronous reset mid-cycle with count=2 and an ALU write presented.
    do_claims(2);
    alu_wr_en = 1; alu_nzcv = 4'b1111; alu_nzcv_mask = 4'b1111;
    #1;
    rst_n = 0;
    #1;
    chk("lit_async_cpsr", cpsr_out, 32'h0000_00D3);
    chk("lit_async_busy", {31'b0, flags_busy}, 32'h0);
    chk("lit_async_ovf",  {31'b0, err_overflow}, 32'h0);
    idle_inputs();
    step();
    rst_n = 1;
    step();

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      idle_inputs();
      flag_claim    = ($urandom_range(0, 99) < 45);
      alu_wr_en     = ($urandom_range(0, 99) < 40);
      flush         = ($urandom_range(0, 99) < 4);
      alu_nzcv      = 4'($urandom_range(0, 15));
      alu_nzcv_mask = 4'($urandom_range(0, 15));
      msr_wr_en     = ($urandom_range(0, 99) < 25);
      msr_data      = $urandom;
      if ($urandom_range(0, 1) == 1) msr_data[4:0] = 5'b10000;
      msr_field_mask = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 299) == 0) rst_n = 0;
      step();
      rst_n = 1;
    end

    idle_inputs();
    step();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
